// File: rtl/ring_input_buffer.sv
// Ring input stage: accepts upstream packets into even/odd VC slots and routes each
// slot to the local PE (hop==0) or to the next hop with the hop field decremented.
`default_nettype none

module ring_input_buffer #(
  parameter int DATA_WIDTH = 64,
  parameter int VC_BIT     = 63,
  parameter int HOP_LSB    = 48,
  parameter int HOP_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  polarity_i,
  input  logic                  si_i,
  output logic                  ri_o,
  input  logic [DATA_WIDTH-1:0] di_i,
  output logic                  request_pe_even_o,
  output logic                  request_pe_odd_o,
  input  logic                  grant_pe_even_i,
  input  logic                  grant_pe_odd_i,
  output logic [DATA_WIDTH-1:0] data_pe_even_o,
  output logic [DATA_WIDTH-1:0] data_pe_odd_o,
  output logic                  request_out_even_o,
  output logic                  request_out_odd_o,
  input  logic                  grant_out_even_i,
  input  logic                  grant_out_odd_i,
  output logic [DATA_WIDTH-1:0] data_out_even_o,
  output logic [DATA_WIDTH-1:0] data_out_odd_o,
  output logic                  err_o
);

  localparam logic [1:0] S_EMPTY    = 2'd0;
  localparam logic [1:0] S_HOLD_PE  = 2'd1;
  localparam logic [1:0] S_HOLD_OUT = 2'd2;
  localparam logic [1:0] S_DRAIN    = 2'd3;

  logic [1:0]            w_empty;
  logic [1:0]            w_req_pe;
  logic [1:0]            w_req_out;
  logic [1:0]            w_gnt_pe;
  logic [1:0]            w_gnt_out;
  logic [DATA_WIDTH-1:0] w_data_pe  [2];
  logic [DATA_WIDTH-1:0] w_data_out [2];
  logic                  w_accept;
  logic                  w_hop_zero;
  logic [DATA_WIDTH-1:0] w_fwd;
  logic                  err_q;
  logic                  err_d;

  assign w_gnt_pe  = {grant_pe_odd_i, grant_pe_even_i};
  assign w_gnt_out = {grant_out_odd_i, grant_out_even_i};

  // ri is forced low while reset is held, even though both slots are EMPTY.
  assign ri_o       = rst_n & w_empty[polarity_i];
  assign w_accept   = si_i & ri_o;
  assign w_hop_zero = (di_i[HOP_LSB +: HOP_WIDTH] == '0);

  always_comb begin
    w_fwd = di_i;
    w_fwd[HOP_LSB +: HOP_WIDTH] = di_i[HOP_LSB +: HOP_WIDTH] - HOP_WIDTH'(1);
  end

  for (genvar s = 0; s < 2; s++) begin : g_slot
    logic [1:0]            state_q, state_d;
    logic                  route_pe_q, route_pe_d;
    logic [DATA_WIDTH-1:0] data_pe_q, data_pe_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic                  write;
    logic                  rel_grant;
    logic                  req_pe, req_out, empty;

    assign write     = w_accept & (polarity_i == 1'(s));
    assign rel_grant = route_pe_q ? w_gnt_pe[s] : w_gnt_out[s];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q    <= S_EMPTY;
        route_pe_q <= 1'b0;
        data_pe_q  <= '0;
        data_out_q <= '0;
      end else begin
        state_q    <= state_d;
        route_pe_q <= route_pe_d;
        data_pe_q  <= data_pe_d;
        data_out_q <= data_out_d;
      end
    end

    always_comb begin
      state_d    = state_q;
      route_pe_d = route_pe_q;
      data_pe_d  = data_pe_q;
      data_out_d = data_out_q;
      case (state_q)
        S_EMPTY: begin
          if (write) begin
            route_pe_d = w_hop_zero;
            if (w_hop_zero) begin
              data_pe_d = di_i;
              state_d   = S_HOLD_PE;
            end else begin
              data_out_d = w_fwd;
              state_d    = S_HOLD_OUT;
            end
          end
        end
        S_HOLD_PE:  if (w_gnt_pe[s])  state_d = S_DRAIN;
        S_HOLD_OUT: if (w_gnt_out[s]) state_d = S_DRAIN;
        // Wait for the grant to fall so a long grant is consumed only once.
        S_DRAIN:    if (!rel_grant)   state_d = S_EMPTY;
        default:    state_d = S_EMPTY;
      endcase
    end

    always_comb begin
      req_pe  = (state_q == S_HOLD_PE);
      req_out = (state_q == S_HOLD_OUT);
      empty   = (state_q == S_EMPTY);
    end

    assign w_req_pe[s]   = req_pe;
    assign w_req_out[s]  = req_out;
    assign w_empty[s]    = empty;
    assign w_data_pe[s]  = data_pe_q;
    assign w_data_out[s] = data_out_q;
  end

  assign err_d = err_q | (si_i & ~ri_o) | (w_accept & (di_i[VC_BIT] != polarity_i));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign request_pe_even_o  = w_req_pe[0];
  assign request_pe_odd_o   = w_req_pe[1];
  assign request_out_even_o = w_req_out[0];
  assign request_out_odd_o  = w_req_out[1];
  assign data_pe_even_o     = w_data_pe[0];
  assign data_pe_odd_o      = w_data_pe[1];
  assign data_out_even_o    = w_data_out[0];
  assign data_out_odd_o     = w_data_out[1];
  assign err_o              = err_q;

endmodule

`default_nettype wire

// File: tb/tb_ring_input_buffer.sv
// Bench for ring_input_buffer: directed scenarios plus random traffic against a slot model.
`default_nettype none

module tb_ring_input_buffer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        polarity_i = 1'b0;
  logic        si_i = 1'b0;
  logic        ri_o;
  logic [63:0] di_i = '0;
  logic        request_pe_even_o, request_pe_odd_o;
  logic        grant_pe_even_i = 1'b0, grant_pe_odd_i = 1'b0;
  logic [63:0] data_pe_even_o, data_pe_odd_o;
  logic        request_out_even_o, request_out_odd_o;
  logic        grant_out_even_i = 1'b0, grant_out_odd_i = 1'b0;
  logic [63:0] data_out_even_o, data_out_odd_o;
  logic        err_o;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural slot model: occupied / destined-for-PE / waiting-for-grant-release
  bit          m_busy  [2];
  bit          m_pe    [2];
  bit          m_drain [2];
  logic [63:0] m_dpe   [2];
  logic [63:0] m_dout  [2];
  bit          m_err;

  always #5 clk = ~clk;

  ring_input_buffer dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .polarity_i        (polarity_i),
    .si_i              (si_i),
    .ri_o              (ri_o),
    .di_i              (di_i),
    .request_pe_even_o (request_pe_even_o),
    .request_pe_odd_o  (request_pe_odd_o),
    .grant_pe_even_i   (grant_pe_even_i),
    .grant_pe_odd_i    (grant_pe_odd_i),
    .data_pe_even_o    (data_pe_even_o),
    .data_pe_odd_o     (data_pe_odd_o),
    .request_out_even_o(request_out_even_o),
    .request_out_odd_o (request_out_odd_o),
    .grant_out_even_i  (grant_out_even_i),
    .grant_out_odd_i   (grant_out_odd_i),
    .data_out_even_o   (data_out_even_o),
    .data_out_odd_o    (data_out_odd_o),
    .err_o             (err_o)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < 2; k++) begin
      m_busy[k] = 0; m_pe[k] = 0; m_drain[k] = 0;
      m_dpe[k] = '0; m_dout[k] = '0;
    end
    m_err = 0;
  endtask

  task automatic check_model();
    chk("ri", ri_o, (rst_n && !m_busy[polarity_i]) ? 1 : 0);
    chk("req_pe_even",  request_pe_even_o,  (m_busy[0] && !m_drain[0] &&  m_pe[0]) ? 1 : 0);
    chk("req_pe_odd",   request_pe_odd_o,   (m_busy[1] && !m_drain[1] &&  m_pe[1]) ? 1 : 0);
    chk("req_out_even", request_out_even_o, (m_busy[0] && !m_drain[0] && !m_pe[0]) ? 1 : 0);
    chk("req_out_odd",  request_out_odd_o,  (m_busy[1] && !m_drain[1] && !m_pe[1]) ? 1 : 0);
    chk("data_pe_even",  data_pe_even_o,  m_dpe[0]);
    chk("data_pe_odd",   data_pe_odd_o,   m_dpe[1]);
    chk("data_out_even", data_out_even_o, m_dout[0]);
    chk("data_out_odd",  data_out_odd_o,  m_dout[1]);
    chk("err", err_o, m_err);
  endtask

  // One clock: drive inputs, check current outputs, advance model across the edge.
  task automatic cycle(input bit pol, input bit s, input logic [63:0] d,
                       input bit [1:0] gpe, input bit [1:0] gout);
    bit ready, acc, grant;
    logic [63:0] fwd;
    polarity_i = pol; si_i = s; di_i = d;
    grant_pe_even_i  = gpe[0];  grant_pe_odd_i  = gpe[1];
    grant_out_even_i = gout[0]; grant_out_odd_i = gout[1];
    #1;
    check_model();
    @(posedge clk);
    ready = !m_busy[pol];
    acc   = s && ready;
    if (s && !ready) m_err = 1;
    if (acc && d[63] != pol) m_err = 1;
    for (int k = 0; k < 2; k++) begin
      grant = m_pe[k] ? gpe[k] : gout[k];
      if (!m_busy[k]) begin
        if (acc && int'(pol) == k) begin
          m_busy[k] = 1; m_drain[k] = 0;
          m_pe[k] = (d[55:48] == 8'd0);
          if (m_pe[k]) m_dpe[k] = d;
          else begin
            fwd = d;
            fwd[55:48] = d[55:48] - 8'd1;
            m_dout[k] = fwd;
          end
        end
      end else if (!m_drain[k]) begin
        if (grant) m_drain[k] = 1;
      end else if (!grant) begin
        m_busy[k] = 0; m_drain[k] = 0;
      end
    end
    #1;
  endtask

  // Asserts reset at the current time (between edges), checks, releases one edge later.
  task automatic do_reset();
    rst_n = 1'b0;
    si_i  = 1'b1;
    #1;
    chk("rst_ri", ri_o, 0);
    chk("rst_reqs", {request_pe_even_o, request_pe_odd_o, request_out_even_o, request_out_odd_o}, 0);
    chk("rst_data", data_pe_even_o | data_pe_odd_o | data_out_even_o | data_out_odd_o, 0);
    chk("rst_err", err_o, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    si_i  = 1'b0;
    model_clear();
  endtask

  initial begin
    bit pol;
    logic [63:0] d;
    model_clear();
    #1;
    do_reset();

    // PE delivery, grant held three cycles
    cycle(0, 1, 64'h0000_0000_0000_00AB, 2'b00, 2'b00);
    chk("pe_req", request_pe_even_o, 1);
    chk("pe_data", data_pe_even_o, 64'hAB);
    chk("pe_ri", ri_o, 0);
    cycle(0, 0, '0, 2'b01, 2'b00);
    chk("pe_req_drop", request_pe_even_o, 0);
    cycle(0, 0, '0, 2'b01, 2'b00);
    cycle(0, 0, '0, 2'b01, 2'b00);
    chk("pe_drain_ri", ri_o, 0);
    cycle(0, 0, '0, 2'b00, 2'b00);
    chk("pe_empty_ri", ri_o, 1);

    // Forwarding with hop decrement
    cycle(1, 1, 64'h8003_0000_1234_5678, 2'b00, 2'b00);
    chk("fwd_req", request_out_odd_o, 1);
    chk("fwd_data", data_out_odd_o, 64'h8002_0000_1234_5678);
    cycle(1, 0, '0, 2'b00, 2'b10);
    chk("fwd_drain", {request_out_odd_o, ri_o}, 2'b00);
    cycle(1, 0, '0, 2'b00, 2'b00);
    chk("fwd_empty_ri", ri_o, 1);

    // Independent slots, then overflow on an occupied slot
    cycle(0, 1, 64'h0000_0000_0000_0011, 2'b00, 2'b00);
    cycle(1, 1, 64'h8002_0000_0000_0022, 2'b00, 2'b00);
    chk("both_req", {request_pe_even_o, request_out_odd_o}, 2'b11);
    cycle(1, 0, '0, 2'b00, 2'b10);
    chk("indep_even_req", request_pe_even_o, 1);
    chk("indep_even_data", data_pe_even_o, 64'h11);
    cycle(1, 0, '0, 2'b00, 2'b00);
    cycle(0, 1, 64'h0000_0000_0000_FFFF, 2'b00, 2'b00);
    chk("ovf_err", err_o, 1);
    chk("ovf_data", data_pe_even_o, 64'h11);
    cycle(0, 0, '0, 2'b01, 2'b00);
    cycle(0, 0, '0, 2'b00, 2'b00);

    // VC mismatch still stores the packet in slot[polarity]
    do_reset();
    cycle(0, 1, 64'h8000_0000_0000_0055, 2'b00, 2'b00);
    chk("vc_err", err_o, 1);
    chk("vc_slot", {request_pe_even_o, request_pe_odd_o}, 2'b10);
    chk("vc_data", data_pe_even_o, 64'h8000_0000_0000_0055);

    // Asynchronous reset between edges
    do_reset();
    cycle(0, 1, 64'h0001_0000_0000_0077, 2'b00, 2'b00);
    chk("ar_req", request_out_even_o, 1);
    chk("ar_data", data_out_even_o, 64'h0000_0000_0000_0077);
    #3;
    do_reset();
    for (int i = 0; i < 4; i++) cycle(0, 0, '0, 2'b00, 2'b00);
    chk("ar_no_rereq", request_out_even_o, 0);

    // Random traffic against the model
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        #2;
        do_reset();
      end
      pol = 1'($urandom_range(0, 1));
      d = {$urandom, $urandom};
      d[55:48] = ($urandom_range(0, 1) == 1) ? 8'd0 : 8'($urandom_range(1, 255));
      d[63] = ($urandom_range(0, 15) == 0) ? ~pol : pol;
      cycle(pol, ($urandom_range(0, 2) != 0), d,
            {($urandom_range(0, 4) < 2), ($urandom_range(0, 4) < 2)},
            {($urandom_range(0, 4) < 2), ($urandom_range(0, 4) < 2)});
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
